// File: rtl/cart_pkg.sv
// Shared types and the PRG address-mapping function for the cartridge PRG mapper.
package cart_pkg;

    typedef enum logic [1:0] {
        MAP_NROM  = 2'd0,
        MAP_UXROM = 2'd2
    } mapper_mode_t;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } prg_fsm_t;

    localparam int unsigned BANK_AW    = 14;
    localparam int unsigned BANK_SEL_W = 4;
    localparam int unsigned PRG_MAP_W  = BANK_AW + BANK_SEL_W;

    // CPU bank 0 ($8000) is switchable in UxROM; bank 1 ($C000) is fixed to the last bank.
    function automatic logic [PRG_MAP_W-1:0] prg_map(
        input mapper_mode_t    mode,
        input int unsigned     banks,
        input logic [14:0]     prg_a,
        input logic [BANK_SEL_W-1:0] bank_reg
    );
        logic [BANK_SEL_W-1:0] bank;
        bank = '0;
        if (mode == MAP_UXROM) begin
            bank = prg_a[14] ? BANK_SEL_W'(banks - 1) : bank_reg;
        end else if (banks != 1) begin
            bank = {{(BANK_SEL_W-1){1'b0}}, prg_a[14]};
        end
        return {bank, prg_a[BANK_AW-1:0]};
    endfunction

endpackage

// File: rtl/cart_prg_mapper.sv
// NROM/UxROM PRG mapper: maps CPU PRG accesses onto SDRAM reads and caches the last byte.
module cart_prg_mapper
    import cart_pkg::*;
#(
    parameter int unsigned PRG_BANKS   = 2,
    parameter int unsigned MAPPER_MODE = 0,
    parameter int unsigned MIRROR      = 1,
    parameter int unsigned MEM_AW      = 21
) (
    input  logic              clk_mem,
    input  logic              rst_n,
    input  logic              prg_nce_in,
    input  logic [14:0]       prg_a_in,
    input  logic              prg_r_nw_in,
    input  logic [7:0]        prg_d_in,
    output logic [7:0]        prg_d_out,
    input  logic [13:0]       chr_a_in,
    output logic              ciram_nce_out,
    output logic              ciram_a10_out,
    output logic              rst_out,
    output logic [MEM_AW-1:0] mem_address,
    output logic              mem_req,
    input  logic              mem_ready,
    input  logic [7:0]        from_mem
);

    localparam mapper_mode_t MODE = mapper_mode_t'(MAPPER_MODE);

    prg_fsm_t                state_q, state_d;
    logic                    rst_out_q = 1'b1;
    logic                    rst_out_d;
    logic                    mem_req_q, mem_req_d;
    logic [MEM_AW-1:0]       mem_address_q, mem_address_d;
    logic [MEM_AW-1:0]       last_addr_q, last_addr_d;
    logic [7:0]              data_q, data_d;
    logic                    valid_q, valid_d;
    logic [BANK_SEL_W-1:0]   bank_q, bank_d;
    logic [MEM_AW-1:0]       mapped_addr;
    logic                    unused_chr;

    assign mapped_addr   = MEM_AW'(prg_map(MODE, PRG_BANKS, prg_a_in, bank_q));
    assign ciram_nce_out = ~chr_a_in[13];
    assign ciram_a10_out = (MIRROR == 1) ? chr_a_in[10] : chr_a_in[11];
    assign unused_chr    = ^{chr_a_in[12], chr_a_in[9:0]};

    assign prg_d_out   = prg_nce_in ? 8'h00 : data_q;
    assign rst_out     = rst_out_q;
    assign mem_req     = mem_req_q;
    assign mem_address = mem_address_q;

    always_comb begin
        state_d       = state_q;
        rst_out_d     = rst_out_q;
        mem_req_d     = 1'b0;
        mem_address_d = mem_address_q;
        last_addr_d   = last_addr_q;
        data_d        = data_q;
        valid_d       = valid_q;
        bank_d        = bank_q;

        if (MODE == MAP_UXROM && !prg_nce_in && !prg_r_nw_in) begin
            bank_d = BANK_SEL_W'(prg_d_in % 8'(PRG_BANKS));
        end

        // Address changes during REQ/WAIT are not tracked; IDLE re-compares afterwards.
        case (state_q)
            ST_INIT: begin
                if (mem_ready) begin
                    state_d   = ST_IDLE;
                    rst_out_d = 1'b0;
                end
            end
            ST_IDLE: begin
                if (mapped_addr != last_addr_q || !valid_q) begin
                    mem_address_d = mapped_addr;
                    last_addr_d   = mapped_addr;
                    mem_req_d     = 1'b1;
                    state_d       = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    data_d  = from_mem;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_mem) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            rst_out_q     <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_address_q <= '0;
            last_addr_q   <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            bank_q        <= '0;
        end else begin
            state_q       <= state_d;
            rst_out_q     <= rst_out_d;
            mem_req_q     <= mem_req_d;
            mem_address_q <= mem_address_d;
            last_addr_q   <= last_addr_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            bank_q        <= bank_d;
        end
    end

endmodule

// File: tb/tb_cart_prg_mapper.sv
// Directed bench: instance a is NROM/1 bank/vertical, instance b is UxROM/8 banks/horizontal.
module tb_cart_prg_mapper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        a_rst_n, a_nce, a_rnw, a_cnce, a_a10, a_rst_out, a_req, a_ready;
    logic [14:0] a_a;
    logic [7:0]  a_d, a_dout, a_from;
    logic [13:0] a_chr;
    logic [20:0] a_addr;

    logic        b_rst_n, b_nce, b_rnw, b_cnce, b_a10, b_rst_out, b_req, b_ready;
    logic [14:0] b_a;
    logic [7:0]  b_d, b_dout, b_from;
    logic [13:0] b_chr;
    logic [20:0] b_addr;

    int b_req_cnt = 0;
    always @(posedge clk) if (b_req) b_req_cnt++;

    cart_prg_mapper #(.PRG_BANKS(1), .MAPPER_MODE(0), .MIRROR(1), .MEM_AW(21)) dut_a (
        .clk_mem(clk), .rst_n(a_rst_n), .prg_nce_in(a_nce), .prg_a_in(a_a),
        .prg_r_nw_in(a_rnw), .prg_d_in(a_d), .prg_d_out(a_dout), .chr_a_in(a_chr),
        .ciram_nce_out(a_cnce), .ciram_a10_out(a_a10), .rst_out(a_rst_out),
        .mem_address(a_addr), .mem_req(a_req), .mem_ready(a_ready), .from_mem(a_from)
    );

    cart_prg_mapper #(.PRG_BANKS(8), .MAPPER_MODE(2), .MIRROR(0), .MEM_AW(21)) dut_b (
        .clk_mem(clk), .rst_n(b_rst_n), .prg_nce_in(b_nce), .prg_a_in(b_a),
        .prg_r_nw_in(b_rnw), .prg_d_in(b_d), .prg_d_out(b_dout), .chr_a_in(b_chr),
        .ciram_nce_out(b_cnce), .ciram_a10_out(b_a10), .rst_out(b_rst_out),
        .mem_address(b_addr), .mem_req(b_req), .mem_ready(b_ready), .from_mem(b_from)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (a_req) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_b_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (b_req) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    // Called while mem_req is high: move into WAIT, then deliver one ready pulse.
    task automatic serve_a(input logic [7:0] v);
        tick();
        a_from = v; a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
    endtask

    task automatic serve_b(input logic [7:0] v);
        tick();
        b_from = v; b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit early_drop;
        a_rst_n = 0; b_rst_n = 0;
        a_nce = 1; a_a = '0; a_rnw = 1; a_d = '0; a_chr = '0; a_ready = 0; a_from = '0;
        b_nce = 1; b_a = '0; b_rnw = 1; b_d = '0; b_chr = '0; b_ready = 0; b_from = '0;
        repeat (3) tick();
        a_nce = 0;
        #1;
        tests_run++; if (a_rst_out !== 1'b1) begin tests_failed++; $display("FAIL reset_rst_out: got %b want 1", a_rst_out); end
        tests_run++; if (a_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %b want 0", a_req); end
        tests_run++; if (a_addr !== 21'h0) begin tests_failed++; $display("FAIL reset_mem_address: got %h want 0", a_addr); end
        tests_run++; if (a_dout !== 8'h00) begin tests_failed++; $display("FAIL reset_prg_d_out: got %h want 00", a_dout); end
        a_rst_n = 1; b_rst_n = 1;
        early_drop = 1'b0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (a_rst_out !== 1'b1 || a_req !== 1'b0 || b_rst_out !== 1'b1) early_drop = 1'b1;
        end
        tests_run++; if (early_drop) begin tests_failed++; $display("FAIL init_hold: got early release want rst_out=1 mem_req=0"); end
        a_ready = 1; b_ready = 1;
        tick();
        a_ready = 0; b_ready = 0;
        tests_run++; if (a_rst_out !== 1'b0) begin tests_failed++; $display("FAIL init_release: got %b want 0", a_rst_out); end
        tests_run++; if (a_req !== 1'b0) begin tests_failed++; $display("FAIL init_req_early: got %b want 0", a_req); end
        tick();
        tests_run++; if (a_req !== 1'b1 || a_addr !== 21'h0) begin tests_failed++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", a_req, a_addr); end
        tick();
        tests_run++; if (a_req !== 1'b0) begin tests_failed++; $display("FAIL req_one_cycle: got %b want 0", a_req); end
        a_from = 8'h77; a_ready = 1; b_from = 8'h66; b_ready = 1;
        tick();
        a_ready = 0; b_ready = 0; b_nce = 0;
        #1;
        tests_run++; if (a_dout !== 8'h77) begin tests_failed++; $display("FAIL first_data_a: got %h want 77", a_dout); end
        tests_run++; if (b_dout !== 8'h66) begin tests_failed++; $display("FAIL first_data_b: got %h want 66", b_dout); end
    endtask

    task automatic test_nrom_read();
        bit ok;
        a_a = 15'h4123;
        wait_a_req(ok);
        tests_run++; if (!ok || a_addr !== 21'h00123) begin tests_failed++; $display("FAIL nrom_addr: got ok=%b addr=%h want 00123", ok, a_addr); end
        a_from = 8'h33; a_ready = 1;
        tick();
        a_ready = 0;
        tick();
        tests_run++; if (a_dout !== 8'h77 || a_req !== 1'b0) begin tests_failed++; $display("FAIL ready_in_req_ignored: got d=%h req=%b want 77/0", a_dout, a_req); end
        a_from = 8'hA5; a_ready = 1;
        tick();
        a_ready = 0;
        tests_run++; if (a_dout !== 8'hA5) begin tests_failed++; $display("FAIL nrom_data: got %h want a5", a_dout); end
        a_nce = 1;
        #1;
        tests_run++; if (a_dout !== 8'h00) begin tests_failed++; $display("FAIL nce_high_out: got %h want 00", a_dout); end
        a_nce = 0;
        a_from = 8'hFF; a_ready = 1;
        tick();
        a_ready = 0;
        tests_run++; if (a_dout !== 8'hA5) begin tests_failed++; $display("FAIL ready_in_idle_ignored: got %h want a5", a_dout); end
        a_rnw = 0; a_d = 8'h05;
        tick();
        a_rnw = 1;
        tick(); tick();
        tests_run++; if (a_req !== 1'b0 || a_dout !== 8'hA5) begin tests_failed++; $display("FAIL nrom_write_ignored: got req=%b d=%h want 0/a5", a_req, a_dout); end
    endtask

    task automatic test_uxrom_bank();
        bit ok;
        b_rnw = 0; b_d = 8'h0B; b_a = 15'h0000;
        tick();
        b_rnw = 1; b_a = 15'h0010;
        wait_b_req(ok);
        tests_run++; if (!ok || b_addr !== 21'h0C010) begin tests_failed++; $display("FAIL uxrom_switch_addr: got ok=%b addr=%h want 0c010", ok, b_addr); end
        serve_b(8'hC1);
        tests_run++; if (b_dout !== 8'hC1) begin tests_failed++; $display("FAIL uxrom_switch_data: got %h want c1", b_dout); end
        b_a = 15'h4010;
        wait_b_req(ok);
        tests_run++; if (!ok || b_addr !== 21'h1C010) begin tests_failed++; $display("FAIL uxrom_fixed_addr: got ok=%b addr=%h want 1c010", ok, b_addr); end
        serve_b(8'hD2);
        b_rnw = 0; b_d = 8'h0D;
        tick();
        b_rnw = 1;
        tick(); tick();
        tests_run++; if (b_req !== 1'b0 || b_dout !== 8'hD2) begin tests_failed++; $display("FAIL fixed_bank_no_refetch: got req=%b d=%h want 0/d2", b_req, b_dout); end
        b_a = 15'h0010;
        wait_b_req(ok);
        tests_run++; if (!ok || b_addr !== 21'h14010) begin tests_failed++; $display("FAIL uxrom_modulo_addr: got ok=%b addr=%h want 14010", ok, b_addr); end
        serve_b(8'hE3);
        b_rnw = 0; b_d = 8'h0A;
        tick();
        b_rnw = 1;
        wait_b_req(ok);
        tests_run++; if (!ok || b_addr !== 21'h08010) begin tests_failed++; $display("FAIL bank_change_refetch: got ok=%b addr=%h want 08010", ok, b_addr); end
        serve_b(8'hF4);
        tests_run++; if (b_dout !== 8'hF4) begin tests_failed++; $display("FAIL bank_change_data: got %h want f4", b_dout); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int start_cnt;
        start_cnt = b_req_cnt;
        b_a = 15'h0001;
        wait_b_req(ok);
        tests_run++; if (!ok || b_addr !== 21'h08001) begin tests_failed++; $display("FAIL b2b_first_addr: got ok=%b addr=%h want 08001", ok, b_addr); end
        tick();
        b_a = 15'h0002;
        tick(); tick();
        tests_run++; if (b_addr !== 21'h08001 || b_req !== 1'b0) begin tests_failed++; $display("FAIL b2b_hold: got addr=%h req=%b want 08001/0", b_addr, b_req); end
        b_from = 8'h11; b_ready = 1;
        tick();
        b_ready = 0;
        tests_run++; if (b_dout !== 8'h11) begin tests_failed++; $display("FAIL b2b_first_data: got %h want 11", b_dout); end
        wait_b_req(ok);
        tests_run++; if (!ok || b_addr !== 21'h08002) begin tests_failed++; $display("FAIL b2b_second_addr: got ok=%b addr=%h want 08002", ok, b_addr); end
        serve_b(8'h22);
        repeat (3) tick();
        tests_run++; if (b_dout !== 8'h22) begin tests_failed++; $display("FAIL b2b_second_data: got %h want 22", b_dout); end
        tests_run++; if (b_req_cnt - start_cnt !== 2) begin tests_failed++; $display("FAIL b2b_req_count: got %0d want 2", b_req_cnt - start_cnt); end
    endtask

    task automatic test_mirror();
        a_chr = 14'h2800; b_chr = 14'h2800;
        #1;
        tests_run++; if (a_a10 !== 1'b0 || a_cnce !== 1'b0) begin tests_failed++; $display("FAIL mirror_v_2800: got a10=%b nce=%b want 0/0", a_a10, a_cnce); end
        tests_run++; if (b_a10 !== 1'b1 || b_cnce !== 1'b0) begin tests_failed++; $display("FAIL mirror_h_2800: got a10=%b nce=%b want 1/0", b_a10, b_cnce); end
        a_chr = 14'h0400; b_chr = 14'h0400;
        #1;
        tests_run++; if (a_a10 !== 1'b1 || a_cnce !== 1'b1) begin tests_failed++; $display("FAIL mirror_v_0400: got a10=%b nce=%b want 1/1", a_a10, a_cnce); end
        tests_run++; if (b_a10 !== 1'b0 || b_cnce !== 1'b1) begin tests_failed++; $display("FAIL mirror_h_0400: got a10=%b nce=%b want 0/1", b_a10, b_cnce); end
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        a_a = 15'h0002;
        wait_a_req(ok);
        tests_run++; if (!ok || a_addr !== 21'h00002) begin tests_failed++; $display("FAIL midreset_req: got ok=%b addr=%h want 00002", ok, a_addr); end
        tick();
        a_rst_n = 0;
        tick();
        tests_run++; if (a_req !== 1'b0 || a_rst_out !== 1'b1 || a_dout !== 8'h00 || a_addr !== 21'h0) begin
            tests_failed++; $display("FAIL midreset_state: got req=%b rst=%b d=%h addr=%h want 0/1/00/0", a_req, a_rst_out, a_dout, a_addr);
        end
        a_rst_n = 1;
        tick(); tick();
        tests_run++; if (a_rst_out !== 1'b1 || a_req !== 1'b0) begin tests_failed++; $display("FAIL midreset_wait_init: got rst=%b req=%b want 1/0", a_rst_out, a_req); end
        a_from = 8'h99; a_ready = 1;
        tick();
        a_ready = 0;
        tests_run++; if (a_rst_out !== 1'b0 || a_dout !== 8'h00) begin tests_failed++; $display("FAIL stale_ready_init: got rst=%b d=%h want 0/00", a_rst_out, a_dout); end
        wait_a_req(ok);
        tests_run++; if (!ok || a_addr !== 21'h00002) begin tests_failed++; $display("FAIL midreset_refetch: got ok=%b addr=%h want 00002", ok, a_addr); end
        serve_a(8'h5A);
        tests_run++; if (a_dout !== 8'h5A) begin tests_failed++; $display("FAIL midreset_data: got %h want 5a", a_dout); end
    endtask

    initial begin
        test_reset();
        test_nrom_read();
        test_uxrom_bank();
        test_back_to_back();
        test_mirror();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
